// File: rtl/elevator_pkg.sv
// Shared constants and types for the elevator bank control logic.
// Sizes here are the defaults picked up by the dispatcher parameters.
package elevator_pkg;

   localparam int unsigned N_FLOORS = 10;
   localparam int unsigned FLOOR_W  = 4;
   localparam int unsigned N_CARS   = 3;

   localparam logic [1:0] CAR_A = 2'd0;
   localparam logic [1:0] CAR_B = 2'd1;
   localparam logic [1:0] CAR_C = 2'd2;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_PICK  = 2'd1,
      ST_OFFER = 2'd2
   } disp_state_t;

endpackage

// File: rtl/nearest_car_select.sv
// Picks the available car closest to a target floor; ties resolve to the
// lowest car index (A, then B, then C).
module nearest_car_select #(
   parameter int unsigned FLOOR_W = 4
) (
   input  logic [FLOOR_W-1:0] floor_a,
   input  logic [FLOOR_W-1:0] floor_b,
   input  logic [FLOOR_W-1:0] floor_c,
   input  logic [2:0]         avail,
   input  logic [FLOOR_W-1:0] target,
   output logic [1:0]         car,
   output logic               found
);
   import elevator_pkg::*;

   logic [FLOOR_W-1:0] dist_a;
   logic [FLOOR_W-1:0] dist_b;
   logic [FLOOR_W-1:0] dist_c;
   logic [FLOOR_W-1:0] best;

   always_comb begin
      dist_a = (floor_a > target) ? floor_a - target : target - floor_a;
      dist_b = (floor_b > target) ? floor_b - target : target - floor_b;
      dist_c = (floor_c > target) ? floor_c - target : target - floor_c;
   end

   // Strict less-than keeps the earlier (lower-index) car on equal distance.
   always_comb begin
      car   = CAR_A;
      found = 1'b0;
      best  = '1;
      if (avail[0]) begin
         car   = CAR_A;
         best  = dist_a;
         found = 1'b1;
      end
      if (avail[1] && (!found || dist_b < best)) begin
         car   = CAR_B;
         best  = dist_b;
         found = 1'b1;
      end
      if (avail[2] && (!found || dist_c < best)) begin
         car   = CAR_C;
         best  = dist_c;
         found = 1'b1;
      end
   end

endmodule

// File: rtl/call_dispatcher.sv
// Hall-call scheduler: latches hall buttons, picks the next pending floor in
// round-robin order and offers it to the nearest available car.
module call_dispatcher #(
   parameter int unsigned N_FLOORS = elevator_pkg::N_FLOORS,
   parameter int unsigned FLOOR_W  = elevator_pkg::FLOOR_W,
   parameter int unsigned N_CARS   = elevator_pkg::N_CARS
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [N_FLOORS-1:0] hall_req,
   input  logic [FLOOR_W-1:0]  car_floor_a,
   input  logic [FLOOR_W-1:0]  car_floor_b,
   input  logic [FLOOR_W-1:0]  car_floor_c,
   input  logic [N_CARS-1:0]   car_busy,
   output logic                dispatch_valid,
   output logic [1:0]          dispatch_car,
   output logic [FLOOR_W-1:0]  dispatch_floor,
   input  logic                dispatch_ready,
   output logic [N_FLOORS-1:0] pending
);
   import elevator_pkg::*;

   localparam int unsigned        IDX_W      = $clog2(N_FLOORS);
   localparam int unsigned        CAR_W      = 2;
   localparam logic [FLOOR_W-1:0] LAST_FLOOR = FLOOR_W'(N_FLOORS - 1);

   disp_state_t         state;
   disp_state_t         state_next;
   logic [FLOOR_W-1:0]  car_floor [N_CARS];
   logic [FLOOR_W-1:0]  res_floor [N_CARS];
   logic [N_CARS-1:0]   reserved;
   logic [N_CARS-1:0]   avail;
   logic [FLOOR_W-1:0]  scan_ptr;
   logic [FLOOR_W-1:0]  pick_floor;
   logic                pick_found;
   logic [1:0]          pick_car;
   logic                car_found;
   logic                load;
   logic                handshake;
   logic [N_FLOORS-1:0] clear_mask;
   int unsigned         idx;

   assign car_floor[0] = car_floor_a;
   assign car_floor[1] = car_floor_b;
   assign car_floor[2] = car_floor_c;

   assign handshake = (state == ST_OFFER) && dispatch_ready;

   always_comb begin
      avail = '0;
      for (int unsigned i = 0; i < N_CARS; i++) begin
         avail[i[CAR_W-1:0]] = !car_busy[i[CAR_W-1:0]] && !reserved[i[CAR_W-1:0]] &&
                               (car_floor[i[CAR_W-1:0]] <= LAST_FLOOR);
      end
   end

   // Round-robin: first pending floor at or after scan_ptr, wrapping around.
   always_comb begin
      pick_found = 1'b0;
      pick_floor = '0;
      idx        = 0;
      for (int unsigned off = 0; off < N_FLOORS; off++) begin
         idx = 32'(scan_ptr) + off;
         if (idx >= N_FLOORS) idx = idx - N_FLOORS;
         if (!pick_found && pending[idx[IDX_W-1:0]]) begin
            pick_found = 1'b1;
            pick_floor = FLOOR_W'(idx);
         end
      end
   end

   nearest_car_select #(
      .FLOOR_W(FLOOR_W)
   ) u_sel (
      .floor_a(car_floor_a),
      .floor_b(car_floor_b),
      .floor_c(car_floor_c),
      .avail  (avail),
      .target (pick_floor),
      .car    (pick_car),
      .found  (car_found)
   );

   always_comb begin
      clear_mask = '0;
      if (handshake) clear_mask = {{(N_FLOORS-1){1'b0}}, 1'b1} << dispatch_floor;
   end

   always_comb begin
      state_next = state;
      load       = 1'b0;
      case (state)
         ST_IDLE: begin
            if ((|pending) && (|avail)) state_next = ST_PICK;
         end
         ST_PICK: begin
            if (pick_found && car_found) begin
               state_next = ST_OFFER;
               load       = 1'b1;
            end else begin
               state_next = ST_IDLE;
            end
         end
         ST_OFFER: begin
            if (dispatch_ready) state_next = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_next;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending        <= '0;
         scan_ptr       <= '0;
         dispatch_valid <= 1'b0;
         dispatch_car   <= '0;
         dispatch_floor <= '0;
         reserved       <= '0;
         for (int unsigned i = 0; i < N_CARS; i++) res_floor[i[CAR_W-1:0]] <= '0;
      end else begin
         // A new press of the floor being handed over is dropped: clear wins.
         pending        <= (pending | hall_req) & ~clear_mask;
         dispatch_valid <= (state_next == ST_OFFER);
         if (load) begin
            dispatch_car   <= pick_car;
            dispatch_floor <= pick_floor;
         end
         if (handshake) begin
            scan_ptr <= (dispatch_floor == LAST_FLOOR) ? '0 : dispatch_floor + 1'b1;
         end
         for (int unsigned i = 0; i < N_CARS; i++) begin
            if (handshake && (dispatch_car == i[CAR_W-1:0])) begin
               reserved[i[CAR_W-1:0]]  <= 1'b1;
               res_floor[i[CAR_W-1:0]] <= dispatch_floor;
            end else if (car_busy[i[CAR_W-1:0]] ||
                         (car_floor[i[CAR_W-1:0]] == res_floor[i[CAR_W-1:0]])) begin
               reserved[i[CAR_W-1:0]] <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_call_dispatcher.sv
// Self-checking bench for call_dispatcher: a vector table of single calls plus
// hand-written sequences, with expected assignments queued in a scoreboard.
module tb_call_dispatcher;
   import elevator_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [9:0] hall_req = '0;
   logic [3:0] car_floor_a = '0;
   logic [3:0] car_floor_b = '0;
   logic [3:0] car_floor_c = '0;
   logic [2:0] car_busy = '0;
   logic       dispatch_valid;
   logic [1:0] dispatch_car;
   logic [3:0] dispatch_floor;
   logic       dispatch_ready = 1'b0;
   logic [9:0] pending;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic [1:0] car;
      logic [3:0] floor;
   } exp_t;
   exp_t sb[$];

   typedef struct {
      logic [3:0] fa;
      logic [3:0] fb;
      logic [3:0] fc;
      logic [2:0] busy;
      logic [3:0] press;
      logic [1:0] car;
      logic [3:0] floor;
   } vec_t;
   vec_t vecs[8];

   call_dispatcher #(.N_FLOORS(10), .FLOOR_W(4), .N_CARS(3)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .hall_req      (hall_req),
      .car_floor_a   (car_floor_a),
      .car_floor_b   (car_floor_b),
      .car_floor_c   (car_floor_c),
      .car_busy      (car_busy),
      .dispatch_valid(dispatch_valid),
      .dispatch_car  (dispatch_car),
      .dispatch_floor(dispatch_floor),
      .dispatch_ready(dispatch_ready),
      .pending       (pending)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation still running, required to finish");
      $fatal(1);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n          = 1'b0;
      hall_req       = '0;
      dispatch_ready = 1'b0;
      car_busy       = '0;
      sb.delete();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic press(input logic [9:0] mask);
      hall_req = mask;
      tick();
      hall_req = '0;
   endtask

   task automatic expect_dispatch(input logic [1:0] car, input logic [3:0] floor);
      exp_t e;
      e.car   = car;
      e.floor = floor;
      sb.push_back(e);
   endtask

   task automatic wait_offer(input string name, output int lat);
      exp_t e;
      lat = 0;
      while (!dispatch_valid && lat < 40) begin
         tick();
         lat++;
      end
      check({name, "_valid"}, 32'(dispatch_valid), 32'd1);
      if (dispatch_valid) begin
         check({name, "_sb_nonempty"}, 32'(sb.size() != 0), 32'd1);
         if (sb.size() != 0) begin
            e = sb.pop_front();
            check({name, "_car"}, 32'(dispatch_car), 32'(e.car));
            check({name, "_floor"}, 32'(dispatch_floor), 32'(e.floor));
         end
      end
   endtask

   task automatic accept();
      dispatch_ready = 1'b1;
      tick();
      dispatch_ready = 1'b0;
   endtask

   initial begin
      int         lat;
      bit         seen;
      bit         stable;
      logic [9:0] m;

      vecs[0] = '{fa: 4'd0, fb: 4'd5, fc: 4'd9, busy: 3'b000, press: 4'd6, car: 2'd1, floor: 4'd6};
      vecs[1] = '{fa: 4'd2, fb: 4'd4, fc: 4'd9, busy: 3'b000, press: 4'd3, car: 2'd0, floor: 4'd3};
      vecs[2] = '{fa: 4'd3, fb: 4'd3, fc: 4'd3, busy: 3'b000, press: 4'd3, car: 2'd0, floor: 4'd3};
      vecs[3] = '{fa: 4'd0, fb: 4'd5, fc: 4'd9, busy: 3'b011, press: 4'd2, car: 2'd2, floor: 4'd2};
      vecs[4] = '{fa: 4'd0, fb: 4'd5, fc: 4'd9, busy: 3'b000, press: 4'd9, car: 2'd2, floor: 4'd9};
      vecs[5] = '{fa: 4'd12, fb: 4'd5, fc: 4'd9, busy: 3'b000, press: 4'd0, car: 2'd1, floor: 4'd0};
      vecs[6] = '{fa: 4'd8, fb: 4'd1, fc: 4'd4, busy: 3'b000, press: 4'd0, car: 2'd1, floor: 4'd0};
      vecs[7] = '{fa: 4'd7, fb: 4'd7, fc: 4'd2, busy: 3'b100, press: 4'd4, car: 2'd0, floor: 4'd4};

      do_reset();
      check("reset_valid", 32'(dispatch_valid), 32'd0);
      check("reset_car", 32'(dispatch_car), 32'd0);
      check("reset_floor", 32'(dispatch_floor), 32'd0);
      check("reset_pending", 32'(pending), 32'd0);
      check("reset_reserved", 32'(dut.reserved), 32'd0);
      check("reset_scan_ptr", 32'(dut.scan_ptr), 32'd0);
      check("reset_state", 32'(dut.state), 32'(ST_IDLE));

      for (int v = 0; v < 8; v++) begin
         do_reset();
         car_floor_a = vecs[v].fa;
         car_floor_b = vecs[v].fb;
         car_floor_c = vecs[v].fc;
         car_busy    = vecs[v].busy;
         m = 10'd1 << vecs[v].press;
         press(m);
         expect_dispatch(vecs[v].car, vecs[v].floor);
         check($sformatf("v%0d_pending_set", v), 32'(pending[vecs[v].press]), 32'd1);
         check($sformatf("v%0d_valid_early", v), 32'(dispatch_valid), 32'd0);
         wait_offer($sformatf("v%0d", v), lat);
         // Two edges after the sampling edge: PICK, then OFFER.
         check($sformatf("v%0d_latency", v), 32'(lat), 32'd2);
         accept();
         check($sformatf("v%0d_pending_clr", v), 32'(pending[vecs[v].press]), 32'd0);
         check($sformatf("v%0d_valid_drop", v), 32'(dispatch_valid), 32'd0);
      end

      // Distance-zero assignment: reservation drops without the car moving.
      do_reset();
      car_floor_a = 4'd3; car_floor_b = 4'd3; car_floor_c = 4'd3;
      press(10'd1 << 3);
      expect_dispatch(2'd0, 4'd3);
      wait_offer("dist0", lat);
      accept();
      check("dist0_reserved_set", 32'(dut.reserved), 32'd1);
      tick();
      check("dist0_reserved_clr", 32'(dut.reserved), 32'd0);

      // Round-robin wrap from scan_ptr=8.
      do_reset();
      car_floor_a = 4'd0; car_floor_b = 4'd5; car_floor_c = 4'd9;
      press(10'd1 << 7);
      expect_dispatch(2'd1, 4'd7);
      wait_offer("rr_first", lat);
      accept();
      check("rr_scan_ptr8", 32'(dut.scan_ptr), 32'd8);
      press((10'd1 << 1) | (10'd1 << 8));
      expect_dispatch(2'd2, 4'd8);
      expect_dispatch(2'd0, 4'd1);
      wait_offer("rr_floor8", lat);
      accept();
      wait_offer("rr_floor1", lat);
      accept();
      check("rr_scan_ptr2", 32'(dut.scan_ptr), 32'd2);

      // No car available; ready while not valid must not clear anything.
      do_reset();
      car_floor_a = 4'd0; car_floor_b = 4'd5; car_floor_c = 4'd9;
      car_busy = 3'b111;
      dispatch_ready = 1'b1;
      press(10'd1 << 4);
      expect_dispatch(2'd2, 4'd4);
      seen = 1'b0;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (dispatch_valid) seen = 1'b1;
      end
      check("busy_no_offer", 32'(seen), 32'd0);
      check("busy_pending_held", 32'(pending[4]), 32'd1);
      dispatch_ready = 1'b0;
      car_busy = 3'b011;
      wait_offer("busy_release", lat);
      accept();

      // Backpressure, offer held while the car turns busy, clear beats re-press.
      do_reset();
      car_floor_a = 4'd0; car_floor_b = 4'd5; car_floor_c = 4'd9;
      press(10'd1 << 6);
      expect_dispatch(2'd1, 4'd6);
      wait_offer("bp", lat);
      car_busy = 3'b010;
      stable = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (!dispatch_valid || dispatch_car != 2'd1 || dispatch_floor != 4'd6) stable = 1'b0;
      end
      check("bp_stable", 32'(stable), 32'd1);
      dispatch_ready = 1'b1;
      hall_req = 10'd1 << 6;
      tick();
      dispatch_ready = 1'b0;
      hall_req = '0;
      check("bp_clear_wins", 32'(pending[6]), 32'd0);
      check("bp_valid_drop", 32'(dispatch_valid), 32'd0);
      tick();
      check("bp_still_clear", 32'(pending[6]), 32'd0);
      press(10'd1 << 6);
      check("bp_repress", 32'(pending[6]), 32'd1);

      // Asynchronous reset during an offer.
      do_reset();
      car_floor_a = 4'd0; car_floor_b = 4'd5; car_floor_c = 4'd9;
      press(10'd1 << 5);
      expect_dispatch(2'd1, 4'd5);
      wait_offer("rst_mid", lat);
      #2;
      rst_n = 1'b0;
      #1;
      check("rst_mid_valid", 32'(dispatch_valid), 32'd0);
      check("rst_mid_pending", 32'(pending), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      check("rst_mid_state", 32'(dut.state), 32'(ST_IDLE));
      check("rst_mid_scan_ptr", 32'(dut.scan_ptr), 32'd0);
      check("rst_mid_car", 32'(dispatch_car), 32'd0);
      check("rst_mid_floor", 32'(dispatch_floor), 32'd0);

      check("sb_drained", 32'(sb.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/call_dispatcher.md
# call_dispatcher

Hall-call scheduler for the three-car elevator bank. It latches hall-call buttons into a pending mask, picks the next pending floor in round-robin order, and assigns it to the nearest available car. The assignment is issued to the control unit's per-car objective registers through a valid/ready handshake. It sits between the hall-button inputs and the car objective/prioritizer logic, and observes each car's current floor and moving flag.

## Interface

Parameters:
- N_FLOORS, 10: number of floors; width of the hall-call mask.
- FLOOR_W, 4: floor number width.
- N_CARS, 3: number of cars (A=0, B=1, C=2).

Ports:
- clk, in, 1: single system clock, rising edge.
- rst_n, in, 1: asynchronous, active-low reset.
- hall_req, in, N_FLOORS: hall-button pulses, one bit per floor. Sampled every edge.
- car_floor_a / car_floor_b / car_floor_c, in, FLOOR_W each: current floor of each car.
- car_busy, in, N_CARS: car moving (objective differs from position), one bit per car.
- dispatch_valid, out, 1: an assignment is offered.
- dispatch_car, out, 2: target car index.
- dispatch_floor, out, FLOOR_W: floor assigned to that car.
- dispatch_ready, in, 1: control unit accepts the assignment this edge.
- pending, out, N_FLOORS: outstanding hall calls; drives the button lamps.

## Operation

- **pending**
  - A bit is set at the edge after its hall_req bit is high.
  - A bit is cleared on a dispatch handshake for that floor.
  - If the same floor is set and cleared in the same cycle, clear wins: the car is already heading there.
- **reserved[N_CARS]**
  - A bit is set on handshake for dispatch_car.
  - It is cleared when that car's car_busy is high, or when its floor equals its reserved floor (the zero-distance case).
- **Available car**: car_busy=0, not reserved, and car_floor < N_FLOORS. An out-of-range floor makes the car unavailable.
- **Floor choice**: the lowest pending floor at or above scan_ptr, wrapping modulo N_FLOORS.
  - After a handshake, scan_ptr becomes dispatch_floor+1; it wraps from N_FLOORS-1 to 0.
- **Car choice**: the minimum |car_floor − floor| among available cars.
  - Ties go to the lowest index (A before B before C).
  - A car already at the floor (distance 0) is still dispatched.
- **FSM states**
  - IDLE: go to PICK if pending≠0 and at least one car is available; otherwise stay.
  - PICK: register the chosen floor and car into the dispatch regs, then go to OFFER. If no choice is valid (pending changed, car lost), return to IDLE.
  - OFFER: dispatch_valid=1, with car and floor held stable. On dispatch_ready, perform the handshake and go to IDLE. Otherwise stay.
    - An offer is never withdrawn, even if the car becomes busy during the offer.
- Only one assignment is in flight at a time.

## Timing

- **Reset values**: dispatch_valid=0, dispatch_car=0, dispatch_floor=0, pending=0, reserved=0, scan_ptr=0, state=IDLE.
- **Reset mid-offer**: dispatch_valid drops asynchronously and the pending call is lost.
- **Latency**, with a press sampled at edge k and a car available:
  - pending bit high after edge k.
  - PICK after edge k+1.
  - dispatch_valid high after edge k+2.
- **Handshake**: completes on the first rising edge with valid and ready both high.
  - The pending bit clears and reserved is set at that edge.
  - The next offer is no earlier than 3 edges later (OFFER→IDLE→PICK→OFFER).
- dispatch_ready while valid is low is ignored.
- hall_req held high for several cycles is equivalent to a single press. A re-press after clear re-raises the bit.

## Structure

- **Shared package elevator_pkg**: N_FLOORS, FLOOR_W, N_CARS, car index constants CAR_A/CAR_B/CAR_C, and dispatcher state encodings.
- **Sub-module nearest_car_select** (combinational): inputs are the three car floors, the availability mask and the target floor. Outputs are the car index and a found flag. It uses absolute-difference comparators with lowest-index tie-break.
- **Top block**: pending/reserved registers, round-robin floor finder, FSM, output registers.

## Test plan

- **Single call**: all cars idle at floors 0/5/9; press floor 6 → dispatch_car=1, dispatch_floor=6 after 3 edges; ready → pending[6]=0.
- **Tie and distance 0**: cars at 2/4/9, press floor 3 → car A (tie, lowest index). Cars at 3/3/3, press 3 → car A, floor 3; reserved[A] clears next cycle without busy.
- **Round-robin wrap**: pending floors 1 and 8, scan_ptr=8 → 8 offered first, then 1. scan_ptr ends at 2.
- **No car available**: all car_busy=1 with pending[4]=1 → valid stays 0. Drop car_busy[2] → offer car C, floor 4.
- **Backpressure**: ready held low 5 cycles → valid, car and floor stable throughout. A new press of the same floor during the handshake edge → pending stays 0.
- **Reset mid-offer**: assert rst_n low while valid=1 → valid=0 and pending=0 immediately. After release → state IDLE, scan_ptr=0.
